// File: rtl/ss_capture_if.sv
// Seven-segment display bus plus the decoded readback it produces.
// The display driver side owns the bus lines; the decoder side owns the readback.
interface ss_capture_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic [6:0]            seg_n;
  logic [N_DIGITS-1:0]   an_n;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   digit_valid;
  logic                  frame_done;
  logic                  pattern_err;
  logic                  anode_err;

  modport master (
    output seg_n, an_n,
    input  digits, digit_valid, frame_done, pattern_err, anode_err
  );

  modport slave (
    input  seg_n, an_n,
    output digits, digit_valid, frame_done, pattern_err, anode_err
  );
endinterface

// File: rtl/ss_capture_decoder.sv
// Recovers the hex value shown on each digit of a multiplexed active-low
// seven-segment bus once the bus has been stable for STABLE_CYCLES samples.
module ss_capture_decoder #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  ss_capture_if.slave bus_if
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LOW_W = 4;
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [N_DIGITS-1:0] ALL_SEEN = '1;
  localparam logic [6:0]          BLANK    = 7'b1111111;

  typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic                  frame_q, frame_d;
  logic                  perr_q, perr_d;
  logic                  aerr_q, aerr_d;

  logic                  changed;
  logic [N_DIGITS-1:0]   an_low;
  logic [LOW_W-1:0]      low_cnt;
  logic                  glyph_hit;
  logic [3:0]            glyph_val;
  logic [N_DIGITS-1:0]   seen_nxt;

  // Pattern is g..a, active-low; returns {hit, value}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    case (s)
      7'b1000000: r = 5'b1_0000;
      7'b1111001: r = 5'b1_0001;
      7'b0100100: r = 5'b1_0010;
      7'b0110000: r = 5'b1_0011;
      7'b0011001: r = 5'b1_0100;
      7'b0010010: r = 5'b1_0101;
      7'b0000010: r = 5'b1_0110;
      7'b1111000: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0010000: r = 5'b1_1001;
      7'b0001000: r = 5'b1_1010;
      7'b0000011: r = 5'b1_1011;
      7'b1000110: r = 5'b1_1100;
      7'b0100001: r = 5'b1_1101;
      7'b0000110: r = 5'b1_1110;
      7'b0001110: r = 5'b1_1111;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign changed              = ({bus_if.seg_n, bus_if.an_n} != {seg_q, an_q});
  assign an_low               = ~an_q;
  assign low_cnt              = LOW_W'($countones(an_low));
  assign {glyph_hit, glyph_val} = decode_glyph(seg_q);

  // Sample register, stability counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_WAIT;
      seg_q    <= '1;
      an_q     <= '1;
      cnt_q    <= '0;
      seen_q   <= '0;
      valid_q  <= '0;
      digits_q <= '0;
      frame_q  <= 1'b0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= bus_if.seg_n;
      an_q     <= bus_if.an_n;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      valid_q  <= valid_d;
      digits_q <= digits_d;
      frame_q  <= frame_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

  // Entering CAPTURE on the edge where the counter saturates puts the
  // output update STABLE_CYCLES edges after the first sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    valid_d  = valid_q;
    digits_d = digits_q;
    frame_d  = 1'b0;
    perr_d   = 1'b0;
    aerr_d   = 1'b0;

    if (changed)                cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_WAIT:    if (cnt_d == CNT_MAX) state_d = S_CAPTURE;
      S_CAPTURE: state_d = changed ? S_WAIT : S_HOLD;
      S_HOLD:    if (changed) state_d = S_WAIT;
      default:   state_d = S_WAIT;
    endcase

    if (state_q == S_CAPTURE) begin
      if (low_cnt > LOW_W'(1)) begin
        aerr_d = 1'b1;
      end else if (low_cnt == LOW_W'(1)) begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
          if (an_low[i]) begin
            valid_d[i] = glyph_hit;
            if (glyph_hit) digits_d[4*i +: 4] = glyph_val;
          end
        end
        perr_d   = !glyph_hit && (seg_q != BLANK);
        seen_nxt = seen_q | an_low;
        if (seen_nxt == ALL_SEEN) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_nxt;
        end
      end
    end
  end

  assign bus_if.digits      = digits_q;
  assign bus_if.digit_valid = valid_q;
  assign bus_if.frame_done  = frame_q;
  assign bus_if.pattern_err = perr_q;
  assign bus_if.anode_err   = aerr_q;
endmodule

// File: tb/tb_ss_capture_decoder.sv
// Directed bench for ss_capture_decoder; expected captures are queued when a
// bus pattern is driven and checked on the edge where the readback must change.
module tb_ss_capture_decoder;
  localparam int unsigned ND = 8;
  localparam int unsigned SC = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct {
    int          cyc;
    logic [31:0] digits;
    logic [7:0]  valid;
    logic        frame;
    logic        perr;
    logic        aerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [31:0] m_digits = '0;
  logic [7:0]  m_valid  = '0;
  logic [7:0]  m_seen   = '0;
  logic [31:0] exp_digits = '0;
  logic [7:0]  exp_valid  = '0;

  ss_capture_if #(.N_DIGITS(ND)) bus_if ();

  ss_capture_decoder #(.N_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one capture, queued for the edge it must appear on.
  task automatic model_capture(input logic [6:0] s, input logic [7:0] a, input int at);
    exp_t r;
    int lows;
    int idx;
    int hit;
    lows = 0; idx = 0; hit = -1;
    r.frame = 1'b0; r.perr = 1'b0; r.aerr = 1'b0;
    for (int i = 0; i < 8; i++) if (!a[i]) begin lows++; idx = i; end
    if (lows > 1) begin
      r.aerr = 1'b1;
    end else if (lows == 1) begin
      for (int g = 0; g < 16; g++) if (GLYPH[g] == s) hit = g;
      if (hit >= 0) begin
        m_digits[4*idx +: 4] = 4'(hit);
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        r.perr = (s != BLANK);
      end
      m_seen[idx] = 1'b1;
      if (&m_seen) begin r.frame = 1'b1; m_seen = '0; end
    end
    r.digits = m_digits;
    r.valid  = m_valid;
    r.cyc    = at;
    sb.push_back(r);
  endtask

  // Drive a pattern at a falling edge and hold it for n rising edges.
  task automatic step(input logic [6:0] s, input logic [7:0] a, input int n);
    bus_if.seg_n = s;
    bus_if.an_n  = a;
    if (n >= int'(SC)) model_capture(s, a, cyc + int'(SC) + 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_digits = '0; m_valid = '0; m_seen = '0;
    exp_digits = '0; exp_valid = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Every cycle: either the queued capture lands now, or nothing may move.
  always @(negedge clk) begin
    exp_t r;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        r = sb.pop_front();
        exp_digits = r.digits;
        exp_valid  = r.valid;
        chk("cap_digits", bus_if.digits, r.digits);
        chk("cap_valid", 32'(bus_if.digit_valid), 32'(r.valid));
        chk("cap_frame", 32'(bus_if.frame_done), 32'(r.frame));
        chk("cap_perr", 32'(bus_if.pattern_err), 32'(r.perr));
        chk("cap_aerr", 32'(bus_if.anode_err), 32'(r.aerr));
      end else begin
        chk("hold_digits", bus_if.digits, exp_digits);
        chk("hold_valid", 32'(bus_if.digit_valid), 32'(exp_valid));
        chk("idle_pulses", {29'd0, bus_if.frame_done, bus_if.pattern_err, bus_if.anode_err}, 32'd0);
      end
    end
  end

  initial begin
    bus_if.seg_n = BLANK;
    bus_if.an_n  = 8'hFF;
    do_reset(3);
    chk("reset_digits", bus_if.digits, 32'd0);
    chk("reset_valid", 32'(bus_if.digit_valid), 32'd0);

    // Idle bus right after reset: a capture with no anode does nothing.
    step(BLANK, 8'hFF, 6);

    // Reset in the middle of a stable window, then a full window from scratch.
    step(GLYPH[0], 8'hFE, 2);
    do_reset(2);
    chk("midrst_digits", bus_if.digits, 32'd0);
    chk("midrst_valid", 32'(bus_if.digit_valid), 32'd0);
    step(GLYPH[0], 8'hFE, 6);
    step(BLANK, 8'hFF, 6);

    // Scan glyphs 0..7 across digits 0..7.
    for (int i = 0; i < 8; i++) step(GLYPH[i], ~(8'h01 << i), 6);
    chk("scan_digits", bus_if.digits, 32'h76543210);
    chk("scan_valid", 32'(bus_if.digit_valid), 32'h000000FF);

    // Glitch shorter than the window, then a window exactly long enough.
    step(GLYPH[15], 8'hF7, 3);
    step(BLANK, 8'hFF, 6);
    step(GLYPH[15], 8'hF7, 4);
    step(BLANK, 8'hFF, 6);

    // Valid A on digit 2, then an illegal pattern held well past the window.
    step(GLYPH[10], 8'hFB, 6);
    step(7'b1111110, 8'hFB, 25);

    // Two anodes low, then all anodes high.
    step(GLYPH[10], 8'hFC, 6);
    step(BLANK, 8'hFF, 6);

    // Blank on every digit completes a frame with nothing valid.
    for (int i = 0; i < 8; i++) step(BLANK, ~(8'h01 << i), 6);
    step(BLANK, 8'hFF, 6);

    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_digits", bus_if.digits, 32'h7654FA10);
    chk("final_valid", 32'(bus_if.digit_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
